alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Issue/write-back front end that drives the 8-bit ALU (SELECT codes 000 forward, 001 add, 010 and, 011 or).
- Decodes one instruction at a time, reads operands from an internal 8x8 register file and registers DATA1/DATA2/SELECT toward the ALU.
- Waits a fixed settle time, then writes the ALU RESULT back to the destination register.
- Sits between instruction fetch and the ALU in the simple processor datapath.

Parameters:
- EXEC_CYCLES, 1, full clock cycles the ALU inputs are held before RESULT is sampled; legal range 1..15.
- NUM_REGS, 8, register file depth; fixed by the 3-bit register index.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- INSTR_VALID  in  1  instruction fields valid this cycle.
- INSTR_READY  out  1  unit can accept an instruction.
- OPCODE  in  8  0 loadi, 1 mov, 2 add, 3 sub, 4 and, 5 or; others illegal.
- DEST  in  3  destination register index.
- SRC1  in  3  first source register index.
- SRC2  in  8  immediate for loadi; otherwise low 3 bits are the second source register index.
- ALU_DATA1  out  8  registered operand 1 to the ALU.
- ALU_DATA2  out  8  registered operand 2 to the ALU.
- ALU_SELECT  out  3  registered ALU function select.
- ALU_RESULT  in  8  ALU output.
- WB_VALID  out  1  one-cycle pulse when a register is written.
- ILLEGAL  out  1  one-cycle pulse when an illegal opcode is consumed.
- DBG_ADDR  in  3  debug read index.
- DBG_DATA  out  8  combinational read of register DBG_ADDR.

Behaviour:
- Reset, asynchronous while RESET=1:
  - All 8 registers = 0; ALU_DATA1/ALU_DATA2 = 0; ALU_SELECT = 000.
  - WB_VALID = 0, ILLEGAL = 0, state = IDLE, counter = 0.
  - INSTR_READY = 0 while RESET=1.
  - Reset mid-operation aborts the instruction with no write-back.
- INSTR_READY = (state==IDLE) && !RESET, combinational.
- Accept rule: posedge with INSTR_VALID && INSTR_READY. Fields are sampled at that edge only and may change afterwards.
- States: IDLE -> EXEC -> WB -> IDLE.
- Accept edge N, IDLE -> EXEC, operands captured from current register contents:
  - loadi: DATA2 = SRC2, SELECT = 000.
  - mov: DATA2 = R[SRC2[2:0]], SELECT = 000.
  - add: DATA1 = R[SRC1], DATA2 = R[SRC2[2:0]], SELECT = 001.
  - sub: DATA2 = (~R[SRC2[2:0]]) + 1 (8-bit two's complement, wraps), SELECT = 001.
  - and: SELECT = 010; or: SELECT = 011.
  - DATA1 is loaded with R[SRC1] for every legal opcode and is unused by forward.
  - Illegal opcode: ALU outputs unchanged, state -> WB with no write, ILLEGAL=1 for exactly the WB cycle.
- EXEC: counter loaded with EXEC_CYCLES at edge N and decremented each edge.
  - At edge N+EXEC_CYCLES: R[DEST] <= ALU_RESULT; state -> WB; WB_VALID=1 during the WB cycle.
- WB: one cycle, INSTR_READY=0; next edge -> IDLE.
- Timing: result is visible on DBG_DATA from edge N+EXEC_CYCLES. Maximum throughput is one instruction per EXEC_CYCLES+2 cycles.
- Read-after-write: an instruction accepted after WB sees the written value. There is no overlap, so no forwarding is needed.
- Arithmetic is 8-bit modulo 256; no carry or overflow flags.
- ALU_* outputs hold their last values in IDLE and WB.

Decomposition:
- Shared package holds:
  - Opcode constants (OP_LOADI..OP_OR).
  - ALU select constants (SEL_FWD 000, SEL_ADD 001, SEL_AND 010, SEL_OR 011).
  - State encoding (IDLE, EXEC, WB).
- One sub-module: reg_file_8x8. It has two combinational read ports plus the debug port, one synchronous write port with write enable, and asynchronous clear on RESET.
- The FSM, decode and operand registers stay in alu_issue_unit.

Test Plan:
- Reset then loadi DEST=1 SRC2=0x05 with EXEC_CYCLES=1 -> INSTR_READY low for 2 cycles; WB_VALID pulses once; DBG_DATA[1]=0x05.
- loadi R2=10, then add DEST=3 SRC1=1 SRC2=2 -> ALU_SELECT=001, ALU_DATA1=5, ALU_DATA2=10; R3=15.
- sub DEST=4 SRC1=1 SRC2=2 (5-10) -> ALU_DATA2=0xF6; R4=0xFB. Then and R5=R1&R2=0x00 and or R6=R1|R2=0x0F.
- OPCODE=0x09 -> ILLEGAL pulses one cycle; no WB_VALID; all registers unchanged; INSTR_READY returns after 2 cycles.
- INSTR_VALID held high across back-to-back instructions with EXEC_CYCLES=3 -> each instruction is accepted exactly once, 5 cycles apart, and accept edges coincide with INSTR_READY=1.
- RESET asserted asynchronously (between edges) during EXEC of an add -> outputs clear immediately; no WB_VALID; all registers read 0; next loadi after release works.

Source files
------------

// File: rtl/alu_issue_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_unit_pkg
// Shared constants for the ALU issue/write-back front end:
//   - datapath widths
//   - instruction opcodes (OP_LOADI..OP_OR)
//   - ALU function selects (SEL_FWD..SEL_OR)
//   - issue FSM state encoding
// -----------------------------------------------------------------------------
package alu_issue_unit_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  // Instruction opcodes; any other value is illegal.
  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;

  // ALU function selects.
  localparam logic [2:0] SEL_FWD = 3'b000;
  localparam logic [2:0] SEL_ADD = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_unit_reg_file_8x8.sv
// -----------------------------------------------------------------------------
// reg_file_8x8
// Register file for the issue unit: two combinational read ports, one
// combinational debug read port, one synchronous write port, and an
// asynchronous clear of every entry while reset_i is high.
//
// Ports:
//   clk_i, reset_i          clock, async active-high clear
//   rd_addr1_i/rd_data1_o   read port 1
//   rd_addr2_i/rd_data2_o   read port 2
//   dbg_addr_i/dbg_data_o   debug read port
//   we_i, wr_addr_i, wr_data_i   write port (posedge clk_i)
// -----------------------------------------------------------------------------
module reg_file_8x8
  import alu_issue_unit_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [IDX_W-1:0]  rd_addr1_i,
  output logic [DATA_W-1:0] rd_data1_o,
  input  logic [IDX_W-1:0]  rd_addr2_i,
  output logic [DATA_W-1:0] rd_data2_o,
  input  logic [IDX_W-1:0]  dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // NOTE: this array is cleared by reset on purpose -- software relies on
  // every register reading 0 after reset, so it must be flops, not a RAM macro.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data1_o = regs_q[rd_addr1_i];
  assign rd_data2_o = regs_q[rd_addr2_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
// Issue/write-back front end for the 8-bit ALU. Accepts one instruction at a
// time, reads its operands from the internal register file, registers them
// toward the ALU, waits EXEC_CYCLES clocks for the ALU to settle and writes
// ALU_RESULT back to the destination register.
//
// Ports:
//   CLK, RESET                      clock, async active-high reset
//   INSTR_VALID/INSTR_READY         instruction handshake
//   OPCODE, DEST, SRC1, SRC2        instruction fields (sampled on accept)
//   ALU_DATA1/ALU_DATA2/ALU_SELECT  registered ALU operands and function
//   ALU_RESULT                      ALU output, written back after settling
//   WB_VALID                        one-cycle pulse on register write
//   ILLEGAL                         one-cycle pulse on illegal opcode
//   DBG_ADDR/DBG_DATA               combinational register read for debug
// -----------------------------------------------------------------------------
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int          NUM_REGS    = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       INSTR_VALID,
  output logic       INSTR_READY,
  input  logic [7:0] OPCODE,
  input  logic [2:0] DEST,
  input  logic [2:0] SRC1,
  input  logic [7:0] SRC2,
  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [2:0] ALU_SELECT,
  input  logic [7:0] ALU_RESULT,
  output logic       WB_VALID,
  output logic       ILLEGAL,
  input  logic [2:0] DBG_ADDR,
  output logic [7:0] DBG_DATA
);

  if (EXEC_CYCLES == 0 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
    $error("alu_issue_unit: EXEC_CYCLES must be in 1..15");
  end

  localparam logic [3:0] EXEC_CNT = 4'(EXEC_CYCLES);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [2:0] dest_q;
  logic [7:0] alu_data1_q;
  logic [7:0] alu_data2_q;
  logic [2:0] alu_select_q;
  logic       wb_valid_q;
  logic       illegal_q;

  logic [7:0] rd_data1;
  logic [7:0] rd_data2;
  logic       rf_we;

  // Write-back happens on the last EXEC edge, when the counter is about to
  // reach zero; ALU_RESULT has then been stable for EXEC_CYCLES clocks.
  assign rf_we = (state_q == ST_EXEC) && (cnt_q == 4'd1);

  reg_file_8x8 #(
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk_i      (CLK),
    .reset_i    (RESET),
    .rd_addr1_i (SRC1),
    .rd_data1_o (rd_data1),
    .rd_addr2_i (SRC2[2:0]),
    .rd_data2_o (rd_data2),
    .dbg_addr_i (DBG_ADDR),
    .dbg_data_o (DBG_DATA),
    .we_i       (rf_we),
    .wr_addr_i  (dest_q),
    .wr_data_i  (ALU_RESULT)
  );

  // Decode of the instruction currently presented on the input fields.
  logic       dec_legal;
  logic [7:0] dec_data2;
  logic [2:0] dec_select;

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    dec_legal  = 1'b1;
    dec_data2  = rd_data2;
    dec_select = SEL_FWD;
    case (OPCODE)
      OP_LOADI: dec_data2 = SRC2;
      OP_MOV:   dec_data2 = rd_data2;
      OP_ADD:   dec_select = SEL_ADD;
      OP_SUB: begin
        // Subtraction is an add of the two's-complement negation (wraps).
        dec_data2  = (~rd_data2) + 8'd1;
        dec_select = SEL_ADD;
      end
      OP_AND:   dec_select = SEL_AND;
      OP_OR:    dec_select = SEL_OR;
      default:  dec_legal = 1'b0;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dest_q       <= '0;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_select_q <= SEL_FWD;
      wb_valid_q   <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // READY is implied here: IDLE and not in reset.
          if (INSTR_VALID) begin
            if (dec_legal) begin
              alu_data1_q  <= rd_data1;
              alu_data2_q  <= dec_data2;
              alu_select_q <= dec_select;
              dest_q       <= DEST;
              cnt_q        <= EXEC_CNT;
              state_q      <= ST_EXEC;
            end else begin
              // Illegal: consume it, skip EXEC, leave ALU outputs untouched.
              illegal_q <= 1'b1;
              state_q   <= ST_WB;
            end
          end
        end
        ST_EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            wb_valid_q <= 1'b1;
            state_q    <= ST_WB;
          end
        end
        ST_WB:   state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign INSTR_READY = (state_q == ST_IDLE) && !RESET;
  assign ALU_DATA1   = alu_data1_q;
  assign ALU_DATA2   = alu_data2_q;
  assign ALU_SELECT  = alu_select_q;
  assign WB_VALID    = wb_valid_q;
  assign ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_unit
// Directed bench for alu_issue_unit. Two instances share clock and reset:
// u_dut1 (EXEC_CYCLES=1) runs the table of single instructions and the
// illegal-opcode case; u_dut3 (EXEC_CYCLES=3) runs back-to-back issue and
// the asynchronous reset during EXEC. A small ALU model drives ALU_RESULT.
// -----------------------------------------------------------------------------
module tb_alu_issue_unit;
  import alu_issue_unit_pkg::*;

  typedef struct {
    logic [7:0] op;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [7:0] src2;
    logic [7:0] e_d1;
    logic [7:0] e_d2;
    logic [2:0] e_sel;
    logic [7:0] e_res;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 1 signals
  logic       v1, r1, wb1, ill1;
  logic [7:0] op1, src2_1, d1_1, d2_1, res1, dbgd1;
  logic [2:0] dest1, src1_1, sel1, dbga1;
  // Instance 3 signals
  logic       v3, r3, wb3, ill3;
  logic [7:0] op3, src2_3, d1_3, d2_3, res3, dbgd3;
  logic [2:0] dest3, src1_3, sel3, dbga3;

  int checks = 0;
  int errors = 0;
  int wb3_cnt = 0;
  logic [7:0] exp_regs [8];
  vec_t vecs [9];

  function automatic logic [7:0] alu_model(input logic [2:0] s, input logic [7:0] a,
                                           input logic [7:0] b);
    case (s)
      3'b000:  return b;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return 8'h00;
    endcase
  endfunction

  assign res1 = alu_model(sel1, d1_1, d2_1);
  assign res3 = alu_model(sel3, d1_3, d2_3);

  alu_issue_unit #(.EXEC_CYCLES(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .INSTR_VALID(v1), .INSTR_READY(r1),
    .OPCODE(op1), .DEST(dest1), .SRC1(src1_1), .SRC2(src2_1),
    .ALU_DATA1(d1_1), .ALU_DATA2(d2_1), .ALU_SELECT(sel1), .ALU_RESULT(res1),
    .WB_VALID(wb1), .ILLEGAL(ill1), .DBG_ADDR(dbga1), .DBG_DATA(dbgd1)
  );

  alu_issue_unit #(.EXEC_CYCLES(3)) u_dut3 (
    .CLK(clk), .RESET(rst), .INSTR_VALID(v3), .INSTR_READY(r3),
    .OPCODE(op3), .DEST(dest3), .SRC1(src1_3), .SRC2(src2_3),
    .ALU_DATA1(d1_3), .ALU_DATA2(d2_3), .ALU_SELECT(sel3), .ALU_RESULT(res3),
    .WB_VALID(wb3), .ILLEGAL(ill3), .DBG_ADDR(dbga3), .DBG_DATA(dbgd3)
  );

  always @(negedge clk) begin
    if (wb3 === 1'b1) wb3_cnt++;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Issue one legal instruction on u_dut1 and check every phase of it.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    check({tag, " ready_before"}, 8'(r1), 8'd1);
    op1 = v.op; dest1 = v.dest; src1_1 = v.src1; src2_1 = v.src2;
    dbga1 = v.dest;
    v1 = 1'b1;
    @(negedge clk);  // accept edge has passed; now in EXEC
    v1 = 1'b0;
    // Scramble the fields: the DUT must have sampled them at the accept edge.
    op1 = 8'hFF; dest1 = ~v.dest; src1_1 = ~v.src1; src2_1 = ~v.src2;
    check({tag, " sel"},      8'(sel1), 8'(v.e_sel));
    check({tag, " data1"},    d1_1, v.e_d1);
    check({tag, " data2"},    d2_1, v.e_d2);
    check({tag, " ready_ex"}, 8'(r1), 8'd0);
    check({tag, " wb_ex"},    8'(wb1), 8'd0);
    @(negedge clk);  // WB cycle
    check({tag, " wb_pulse"}, 8'(wb1), 8'd1);
    check({tag, " ill_wb"},   8'(ill1), 8'd0);
    check({tag, " ready_wb"}, 8'(r1), 8'd0);
    check({tag, " result"},   dbgd1, v.e_res);
    exp_regs[v.dest] = v.e_res;
    @(negedge clk);  // back in IDLE
    check({tag, " wb_done"},  8'(wb1), 8'd0);
    check({tag, " ready_idle"}, 8'(r1), 8'd1);
  endtask

  initial begin
    int   acc_cyc [3];
    int   n_acc;
    int   wb_before;
    logic rdy;

    rst = 1'b1;
    v1 = 1'b0; op1 = '0; dest1 = '0; src1_1 = '0; src2_1 = '0; dbga1 = '0;
    v3 = 1'b0; op3 = '0; dest3 = '0; src1_3 = '0; src2_3 = '0; dbga3 = '0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;

    //         op        dest  src1  src2    d1     d2     sel      result
    vecs[0] = '{OP_LOADI, 3'd1, 3'd0, 8'h05, 8'h00, 8'h05, SEL_FWD, 8'h05};
    vecs[1] = '{OP_LOADI, 3'd2, 3'd0, 8'h0A, 8'h00, 8'h0A, SEL_FWD, 8'h0A};
    vecs[2] = '{OP_ADD,   3'd3, 3'd1, 8'h02, 8'h05, 8'h0A, SEL_ADD, 8'h0F};
    vecs[3] = '{OP_SUB,   3'd4, 3'd1, 8'h02, 8'h05, 8'hF6, SEL_ADD, 8'hFB};
    vecs[4] = '{OP_AND,   3'd5, 3'd1, 8'h02, 8'h05, 8'h0A, SEL_AND, 8'h00};
    vecs[5] = '{OP_OR,    3'd6, 3'd1, 8'h02, 8'h05, 8'h0A, SEL_OR,  8'h0F};
    vecs[6] = '{OP_MOV,   3'd7, 3'd0, 8'h03, 8'h00, 8'h0F, SEL_FWD, 8'h0F};
    vecs[7] = '{OP_ADD,   3'd0, 3'd4, 8'h04, 8'hFB, 8'hFB, SEL_ADD, 8'hF6};
    vecs[8] = '{OP_LOADI, 3'd5, 3'd6, 8'hFF, 8'h0F, 8'hFF, SEL_FWD, 8'hFF};

    // ---------------- reset state ----------------
    #1;
    check("rst ready1", 8'(r1), 8'd0);
    check("rst ready3", 8'(r3), 8'd0);
    check("rst wb1",    8'(wb1), 8'd0);
    check("rst ill1",   8'(ill1), 8'd0);
    check("rst data1",  d1_1, 8'h00);
    check("rst data2",  d2_1, 8'h00);
    check("rst sel",    8'(sel1), 8'h00);
    check("rst r0",     dbgd1, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table of single instructions ----------------
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // ---------------- illegal opcode ----------------
    @(negedge clk);
    check("ill ready_before", 8'(r1), 8'd1);
    op1 = 8'h09; dest1 = 3'd3; src1_1 = 3'd1; src2_1 = 8'h02; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; op1 = 8'h00;
    check("ill pulse",   8'(ill1), 8'd1);
    check("ill no_wb",   8'(wb1), 8'd0);
    check("ill ready",   8'(r1), 8'd0);
    check("ill data1",   d1_1, vecs[8].e_d1);
    check("ill data2",   d2_1, vecs[8].e_d2);
    check("ill sel",     8'(sel1), 8'(vecs[8].e_sel));
    @(negedge clk);
    check("ill done",    8'(ill1), 8'd0);
    check("ill no_wb2",  8'(wb1), 8'd0);
    check("ill ready_back", 8'(r1), 8'd1);
    for (int i = 0; i < 8; i++) begin
      dbga1 = 3'(i);
      #1;
      check($sformatf("ill reg%0d", i), dbgd1, exp_regs[i]);
    end

    // ---------------- back-to-back, VALID held high, EXEC_CYCLES=3 ----------------
    n_acc = 0;
    @(negedge clk);
    op3 = OP_LOADI; dest3 = 3'd1; src1_3 = 3'd0; src2_3 = 8'h11; v3 = 1'b1;
    for (int c = 0; c < 60 && n_acc < 3; c++) begin
      rdy = r3;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc == 1) begin
          dest3 = 3'd2; src2_3 = 8'h22;
        end else if (n_acc == 2) begin
          dest3 = 3'd3; src2_3 = 8'h33;
        end else begin
          v3 = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b accepts", 8'(n_acc), 8'd3);
    if (n_acc == 3) begin
      check("b2b gap1", 8'(acc_cyc[1] - acc_cyc[0]), 8'd5);
      check("b2b gap2", 8'(acc_cyc[2] - acc_cyc[1]), 8'd5);
    end
    repeat (6) @(negedge clk);
    check("b2b wb_count", 8'(wb3_cnt), 8'd3);
    check("b2b ready", 8'(r3), 8'd1);
    dbga3 = 3'd0; #1; check("b2b r0", dbgd3, 8'h00);
    dbga3 = 3'd1; #1; check("b2b r1", dbgd3, 8'h11);
    dbga3 = 3'd2; #1; check("b2b r2", dbgd3, 8'h22);
    dbga3 = 3'd3; #1; check("b2b r3", dbgd3, 8'h33);

    // ---------------- async reset during EXEC ----------------
    @(negedge clk);
    op3 = OP_ADD; dest3 = 3'd4; src1_3 = 3'd1; src2_3 = 8'h02; v3 = 1'b1;
    dbga3 = 3'd4;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    check("arst pre data1", d1_3, 8'h11);
    check("arst pre data2", d2_3, 8'h22);
    check("arst pre sel",   8'(sel3), 8'(SEL_ADD));
    wb_before = wb3_cnt;
    #2 rst = 1'b1;  // between edges
    #1;
    check("arst data1",  d1_3, 8'h00);
    check("arst data2",  d2_3, 8'h00);
    check("arst sel",    8'(sel3), 8'h00);
    check("arst ready3", 8'(r3), 8'd0);
    check("arst ready1", 8'(r1), 8'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      dbga3 = 3'(i); dbga1 = 3'(i);
      #1;
      check($sformatf("arst dut3 reg%0d", i), dbgd3, 8'h00);
      check($sformatf("arst dut1 reg%0d", i), dbgd1, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    repeat (4) @(negedge clk);
    check("arst no_wb",   8'(wb3_cnt - wb_before), 8'd0);
    check("arst ready3b", 8'(r3), 8'd1);
    dbga3 = 3'd4; #1;
    check("arst r4", dbgd3, 8'h00);

    // Loadi on u_dut1 after reset release.
    run_vec('{OP_LOADI, 3'd2, 3'd0, 8'h5A, 8'h00, 8'h5A, SEL_FWD, 8'h5A}, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
